// File: rtl/cam_pkg.sv
// Shared camera-path definitions: Bayer CFA orders, RGB565 field widths,
// colour-bar palette and the raw-to-RGB565 truncation helper.
package cam_pkg;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_e;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 16'h07FF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 16'h07E0;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [RGB_W-1:0] BAR_RED     = 16'hF800;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 16'h001F;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 16'h0000;

  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // Channels arrive MSB-aligned in 16 bits, so truncation is a fixed top slice.
  function automatic logic [RGB_W-1:0] raw_to_565(input logic [15:0] r,
                                                  input logic [15:0] g,
                                                  input logic [15:0] b);
    return {r[15 -: R_W], g[15 -: G_W], b[15 -: B_W]};
  endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// Simple dual-port line buffer (one write, one registered read) holding the
// top half of each selected Bayer quad; written so tools infer block RAM.
module bayer_line_buffer #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 20,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bayer_decimate_rgb565.sv
// Bayer RAW to RGB565 quad-decimating converter with regenerated syncs and
// frame status. Optional colour-bar generator enabled by TEST_PATTERN_EN.
module bayer_decimate_rgb565
  import cam_pkg::*;
#(
  parameter int PIX_W     = 10,
  parameter int IN_WIDTH  = 640,
  parameter int IN_HEIGHT = 480,
  parameter int DEC       = 2,
  parameter int BAYER     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             href,
  input  logic             vsync,
`ifdef TEST_PATTERN_EN
  input  logic             tp_on,
`endif
  output logic [15:0]      rgb565,
  output logic             valid_out,
  output logic             href_out,
  output logic             vsync_out,
  output logic             frame_done,
  output logic             line_err
);

  localparam int OUT_WIDTH  = IN_WIDTH / (2 * DEC);
  localparam int OUT_HEIGHT = IN_HEIGHT / (2 * DEC);
  localparam int HW = $clog2(IN_WIDTH + 2);
  localparam int VW = $clog2(IN_HEIGHT + 1);
  localparam int DW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int AW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int LW = $clog2(OUT_HEIGHT + 1);
  localparam logic [HW-1:0] H_LEN    = HW'(IN_WIDTH);
  localparam logic [HW-1:0] H_SAT    = HW'(IN_WIDTH + 1);
  localparam logic [VW-1:0] V_LEN    = VW'(IN_HEIGHT);
  localparam logic [DW-1:0] DEC_LAST = DW'(DEC - 1);
  localparam logic [CW-1:0] OW_C     = CW'(OUT_WIDTH);
  localparam logic [CW-1:0] OW_LAST  = CW'(OUT_WIDTH - 1);
  localparam logic [LW-1:0] OH_C     = LW'(OUT_HEIGHT);
  localparam logic [LW-1:0] OH_LAST  = LW'(OUT_HEIGHT - 1);
  localparam bayer_e ORDER = bayer_e'(BAYER[1:0]);

  logic             href_q, href_d, vsync_q;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [DW-1:0]    qcm_q, qcm_d, qrm_q, qrm_d;
  logic [CW-1:0]    col_q, col_d, ocnt_q, ocnt_d;
  logic [LW-1:0]    oline_q, oline_d;
  logic [PIX_W-1:0] tl_q, tl_d, bl_q, bl_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             valid_q, valid_d, href_out_q, href_out_d;
  logic             line_last_q, line_last_d, frame_done_q, frame_done_d;
  logic             line_err_q, line_err_d;
  logic             buf_we, buf_re, px_ok, h_fall, sel;
  logic [2*PIX_W-1:0] rd_data;

  bayer_line_buffer #(.DEPTH(OUT_WIDTH), .WIDTH(2 * PIX_W), .AW(AW)) u_lbuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col_q[AW-1:0]),
    .wdata ({tl_q, pix_data}),
    .re    (buf_re),
    .raddr (col_q[AW-1:0]),
    .rdata (rd_data)
  );

  // Quad assembly at the BR pixel: top pair from the buffer, BL registered.
  logic [PIX_W-1:0] q_tl, q_tr, q_r, q_g1, q_g2, q_b;
  logic [PIX_W:0]   g_sum;
  logic [RGB_W-1:0] pix565;

  always_comb begin
    q_tl = rd_data[2*PIX_W-1:PIX_W];
    q_tr = rd_data[PIX_W-1:0];
    case (ORDER)
      RGGB:    begin q_r = q_tl; q_g1 = q_tr; q_g2 = bl_q;     q_b = pix_data; end
      GRBG:    begin q_r = q_tr; q_g1 = q_tl; q_g2 = pix_data; q_b = bl_q;     end
      GBRG:    begin q_r = bl_q; q_g1 = q_tl; q_g2 = pix_data; q_b = q_tr;     end
      default: begin q_r = pix_data; q_g1 = q_tr; q_g2 = bl_q; q_b = q_tl;     end
    endcase
    g_sum  = {1'b0, q_g1} + {1'b0, q_g2};
    pix565 = raw_to_565(16'(q_r) << (16 - PIX_W),
                        16'(g_sum[PIX_W:1]) << (16 - PIX_W),
                        16'(q_b) << (16 - PIX_W));
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (OUT_WIDTH / 8 > 0) ? OUT_WIDTH / 8 : 1;
  logic tp_q, tp_d;
  int   bar_i;
`endif

  always_comb begin
    href_d = href;     h_d = h_q;       v_d = v_q;
    qcm_d = qcm_q;     qrm_d = qrm_q;   col_d = col_q;
    ocnt_d = ocnt_q;   oline_d = oline_q;
    tl_d = tl_q;       bl_d = bl_q;     rgb_d = rgb_q;
    line_err_d = line_err_q;
    valid_d = 1'b0;    line_last_d = 1'b0;  frame_done_d = 1'b0;
    href_out_d = 1'b0; buf_we = 1'b0;       buf_re = 1'b0;
    px_ok  = href && !vsync && (h_q < H_LEN) && (v_q < V_LEN);
    h_fall = href_q && !href && !vsync;
    sel    = (qcm_q == '0) && (qrm_q == '0) && (col_q < OW_C) && (oline_q < OH_C);
`ifdef TEST_PATTERN_EN
    tp_d  = (vsync_q && !vsync) ? tp_on : tp_q;
    bar_i = int'(ocnt_q) / BAR_W;
    if (bar_i > 7) bar_i = 7;
`endif
    if (vsync) begin
      h_d = '0; v_d = '0; qcm_d = '0; qrm_d = '0; col_d = '0;
      ocnt_d = '0; oline_d = '0;
      if (!vsync_q) line_err_d = 1'b0;
    end else begin
      if (href) begin
        if (h_q != H_SAT) h_d = h_q + 1'b1;
      end else begin
        h_d = '0; qcm_d = '0; col_d = '0;
      end
      if (px_ok) begin
        if (h_q[0]) begin
          qcm_d = (qcm_q == DEC_LAST) ? '0 : qcm_q + 1'b1;
          if (qcm_q == DEC_LAST) col_d = col_q + 1'b1;
        end
        if (sel) begin
          case ({v_q[0], h_q[0]})
            2'b00:   tl_d = pix_data;
            2'b01:   buf_we = 1'b1;
            2'b10:   begin buf_re = 1'b1; bl_d = pix_data; end
            default: begin
              valid_d = 1'b1;
              rgb_d   = pix565;
`ifdef TEST_PATTERN_EN
              if (tp_q) rgb_d = bar_colour(3'(bar_i));
`endif
            end
          endcase
        end
      end
      if (h_fall) begin
        if (h_q != H_LEN) line_err_d = 1'b1;
        if (v_q != V_LEN) v_d = v_q + 1'b1;
        if (v_q[0] && (v_q < V_LEN)) qrm_d = (qrm_q == DEC_LAST) ? '0 : qrm_q + 1'b1;
        ocnt_d = '0;
      end
      if (valid_d) ocnt_d = ocnt_q + 1'b1;
      line_last_d = valid_d && (ocnt_q == OW_LAST);
      if (line_last_q) begin
        oline_d      = oline_q + 1'b1;
        frame_done_d = (oline_q == OH_LAST);
      end
      // A short output line is closed at the input line end rather than left hanging.
      href_out_d = valid_d || (href_out_q && !line_last_q && !h_fall);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_q <= 1'b0;  vsync_q <= 1'b0;  h_q <= '0;  v_q <= '0;
      qcm_q <= '0;     qrm_q <= '0;      col_q <= '0; ocnt_q <= '0;
      oline_q <= '0;   tl_q <= '0;       bl_q <= '0;  rgb_q <= '0;
      valid_q <= 1'b0; href_out_q <= 1'b0; line_last_q <= 1'b0;
      frame_done_q <= 1'b0; line_err_q <= 1'b0;
    end else begin
      href_q <= href_d;  vsync_q <= vsync;  h_q <= h_d;  v_q <= v_d;
      qcm_q <= qcm_d;    qrm_q <= qrm_d;    col_q <= col_d; ocnt_q <= ocnt_d;
      oline_q <= oline_d; tl_q <= tl_d;     bl_q <= bl_d;  rgb_q <= rgb_d;
      valid_q <= valid_d; href_out_q <= href_out_d; line_last_q <= line_last_d;
      frame_done_q <= frame_done_d; line_err_q <= line_err_d;
    end
  end

`ifdef TEST_PATTERN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tp_q <= 1'b0;
    else     tp_q <= tp_d;
  end
`endif

  assign rgb565     = rgb_q;
  assign valid_out  = valid_q;
  assign href_out   = href_out_q;
  assign vsync_out  = vsync_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

endmodule
